// File: rtl/pwm_multi.sv
// Multi-channel PWM generator.
//
// All channels share one prescaler (pcnt) and one period counter (cnt).
// Each channel owns its duty/polarity in a per-channel instance. Every
// configuration field is double-buffered: load captures a pending set, and
// the pending set moves to the active set only at a period wrap, or at once
// while disabled, so a period is never cut short or stretched.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           run enable; low holds counters at 0, outputs at polarity
//   presc        counter tick every presc+1 clk
//   period       PWM period is period+1 ticks
//   duty         per-channel high time in ticks, channel i at [i*CNT_W +: CNT_W]
//   pol          per-channel output inversion
//   load         strobe, captures presc/period/duty/pol into the pending set
//   pwm_out      registered PWM outputs
//   period_tick  one-clk pulse the cycle after each period wrap
//   pending      a loaded configuration is waiting for a boundary

module pwm_multi_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             cap_i,        // capture inputs into pending
    input  logic             apply_in_i,   // active <= inputs (load at boundary)
    input  logic             apply_pend_i, // active <= pending
    input  logic [CNT_W-1:0] duty_i,
    input  logic             pol_i,
    output logic             pwm_o
);
    logic [CNT_W-1:0] duty_a_q, duty_a_d, duty_p_q, duty_p_d;
    logic             pol_a_q, pol_a_d, pol_p_q, pol_p_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_p_d = cap_i ? duty_i : duty_p_q;
        pol_p_d  = cap_i ? pol_i  : pol_p_q;
        duty_a_d = duty_a_q;
        pol_a_d  = pol_a_q;
        if (apply_in_i) begin
            duty_a_d = duty_i;
            pol_a_d  = pol_i;
        end else if (apply_pend_i) begin
            duty_a_d = duty_p_q;
            pol_a_d  = pol_p_q;
        end
        // Plain unsigned compare: duty above the period simply never
        // goes false, giving 100% without special-casing.
        pwm_d = en_i ? ((cnt_i < duty_a_q) ^ pol_a_q) : pol_a_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_a_q <= '0;
            duty_p_q <= '0;
            pol_a_q  <= 1'b0;
            pol_p_q  <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            duty_a_q <= duty_a_d;
            duty_p_q <= duty_p_d;
            pol_a_q  <= pol_a_d;
            pol_p_q  <= pol_p_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [PRESC_W-1:0]        presc,
    input  logic [CNT_W-1:0]          period,
    input  logic [CHANNELS*CNT_W-1:0] duty,
    input  logic [CHANNELS-1:0]       pol,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic                      pending
);
    logic [PRESC_W-1:0] pcnt_q, pcnt_d, presc_a_q, presc_a_d, presc_p_q, presc_p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, period_a_q, period_a_d, period_p_q, period_p_d;
    logic               pend_q, pend_d, ptick_q;
    logic               tick, wrap, apply, apply_in, apply_pend;

    assign tick  = en && (pcnt_q == presc_a_q);
    assign wrap  = tick && (cnt_q == period_a_q);
    // Boundary: a period wrap, or any cycle while disabled.
    assign apply = wrap || !en;
    // A load landing on a boundary bypasses the pending set entirely.
    assign apply_in   = apply && load;
    assign apply_pend = apply && !load && pend_q;

    always_comb begin
        presc_p_d  = load ? presc  : presc_p_q;
        period_p_d = load ? period : period_p_q;
        presc_a_d  = presc_a_q;
        period_a_d = period_a_q;
        if (apply_in) begin
            presc_a_d  = presc;
            period_a_d = period;
        end else if (apply_pend) begin
            presc_a_d  = presc_p_q;
            period_a_d = period_p_q;
        end

        pend_d = pend_q;
        if (apply)     pend_d = 1'b0;
        else if (load) pend_d = 1'b1;

        // Counters are already 0 after a wrap or while disabled, so applying
        // a new set needs no separate counter reset.
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        if (!en) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        end else begin
            pcnt_d = pcnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q     <= '0;
            cnt_q      <= '0;
            presc_a_q  <= '0;
            presc_p_q  <= '0;
            period_a_q <= '0;
            period_p_q <= '0;
            pend_q     <= 1'b0;
            ptick_q    <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            presc_a_q  <= presc_a_d;
            presc_p_q  <= presc_p_d;
            period_a_q <= period_a_d;
            period_p_q <= period_p_d;
            pend_q     <= pend_d;
            ptick_q    <= wrap;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_multi_ch #(.CNT_W(CNT_W)) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .en_i         (en),
            .cnt_i        (cnt_q),
            .cap_i        (load),
            .apply_in_i   (apply_in),
            .apply_pend_i (apply_pend),
            .duty_i       (duty[g*CNT_W +: CNT_W]),
            .pol_i        (pol[g]),
            .pwm_o        (pwm_out[g])
        );
    end

    assign period_tick = ptick_q;
    assign pending     = pend_q;
endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  presc;
    logic [15:0] period;
    logic [63:0] duty;
    logic [3:0]  pol;
    logic        load;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic        pending;

    pwm_multi #(.CHANNELS(4), .CNT_W(16), .PRESC_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .presc       (presc),
        .period      (period),
        .duty        (duty),
        .pol         (pol),
        .load        (load),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pwm;
        logic       tk;
        logic       pd;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Expected active/next configuration, as the bench understands it.
    int          c_presc, c_per, n_presc, n_per;
    logic [15:0] c_duty[4];
    logic [15:0] n_duty[4];
    logic [3:0]  c_pol, n_pol;
    bit          sw;     // a loaded set is waiting for its boundary
    int          r;      // clk index within the current period
    string       tag;

    // Monitor: one expected entry per clk, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                total += 3;
                if (pwm_out !== e.pwm) begin
                    bad++;
                    $display("FAIL %s pwm_out got=%b want=%b t=%0t", e.tag, pwm_out, e.pwm, $time);
                end
                if (period_tick !== e.tk) begin
                    bad++;
                    $display("FAIL %s period_tick got=%b want=%b t=%0t", e.tag, period_tick, e.tk, $time);
                end
                if (pending !== e.pd) begin
                    bad++;
                    $display("FAIL %s pending got=%b want=%b t=%0t", e.tag, pending, e.pd, $time);
                end
            end
        end
    end

    task automatic zero_model();
        c_presc = 0; c_per = 0; c_pol = '0;
        for (int i = 0; i < 4; i++) c_duty[i] = '0;
        sw = 0; r = 0;
    endtask

    task automatic switch_cfg();
        c_presc = n_presc; c_per = n_per; c_pol = n_pol;
        for (int i = 0; i < 4; i++) c_duty[i] = n_duty[i];
    endtask

    task automatic set_in(input int p, input int per, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3, input logic [3:0] pl);
        presc  = 8'(p);
        period = 16'(per);
        duty   = {d3, d2, d1, d0};
        pol    = pl;
        n_presc = p; n_per = per; n_pol = pl;
        n_duty[0] = d0; n_duty[1] = d1; n_duty[2] = d2; n_duty[3] = d3;
    endtask

    // One clk; pushes what the outputs should show after this edge.
    task automatic cyc();
        exp_t e;
        int   n, cv;
        @(posedge clk);
        #1;
        e.tag = tag;
        if (!rst_n) begin
            e.pwm = '0; e.tk = 1'b0; e.pd = 1'b0;
            zero_model();
        end else if (!en) begin
            e.pwm = c_pol; e.tk = 1'b0;
            if (sw) switch_cfg();
            sw = 0; r = 0;
            e.pd = 1'b0;
        end else begin
            n  = (c_presc + 1) * (c_per + 1);
            cv = r / (c_presc + 1);
            for (int i = 0; i < 4; i++) e.pwm[i] = (cv < int'(c_duty[i])) ^ c_pol[i];
            e.tk = (r == n - 1);
            if (r == n - 1) begin
                r = 0;
                if (sw) switch_cfg();
                sw = 0;
            end else begin
                r++;
            end
            e.pd = sw;
        end
        sbq.push_back(e);
    endtask

    task automatic ld_cyc();
        load = 1'b1;
        sw   = 1;
        cyc();
        load = 1'b0;
    endtask

    task automatic run_until(input int k);
        int g;
        g = 0;
        while (r != k && g < 1000) begin
            cyc();
            g++;
        end
    endtask

    initial begin
        exp_t e;
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        presc = '0; period = '0; duty = '0; pol = '0;
        zero_model();
        n_presc = 0; n_per = 0; n_pol = '0;
        for (int i = 0; i < 4; i++) n_duty[i] = '0;

        tag = "reset";
        cyc(); cyc();
        rst_n = 1'b1;

        // period 10 clk; ch0 duty 3, ch1 duty 0, ch2 duty 10 (>period), ch3 max
        tag = "base";
        set_in(0, 9, 16'd3, 16'd0, 16'd10, 16'hFFFF, 4'b0000);
        ld_cyc();
        en = 1'b1;
        repeat (25) cyc();

        // load mid-period at cnt=4: held pending until the wrap
        tag = "midload";
        run_until(4);
        set_in(0, 9, 16'd7, 16'd0, 16'd10, 16'hFFFF, 4'b0000);
        ld_cyc();
        repeat (20) cyc();

        // load on the wrap cycle: applied directly, pending never rises
        tag = "wrapload";
        run_until(9);
        set_in(0, 9, 16'd3, 16'd0, 16'd10, 16'hFFFF, 4'b0001);
        ld_cyc();
        repeat (20) cyc();

        // two loads in one period: only the second survives
        tag = "twoload";
        run_until(2);
        set_in(0, 9, 16'd1, 16'd0, 16'd10, 16'hFFFF, 4'b0001);
        ld_cyc();
        run_until(5);
        set_in(0, 9, 16'd6, 16'd0, 16'd10, 16'hFFFF, 4'b0000);
        ld_cyc();
        repeat (20) cyc();

        // prescaler 4 clk per tick, period 5 ticks: ch1 high 8 / low 12
        tag = "presc";
        run_until(9);
        set_in(3, 4, 16'd6, 16'd2, 16'd10, 16'hFFFF, 4'b0000);
        ld_cyc();
        repeat (45) cyc();

        // async reset while ch1 is high: everything drops before any edge
        tag = "rstmid";
        run_until(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        e.pwm = '0; e.tk = 1'b0; e.pd = 1'b0; e.tag = tag;
        sbq.push_back(e);
        zero_model();
        #5;
        rst_n = 1'b1;

        // after reset the active period is 0: every tick wraps
        tag = "postrst";
        set_in(0, 9, 16'd3, 16'd0, 16'd0, 16'd0, 4'b1010);
        ld_cyc();
        repeat (12) cyc();

        // pending set applied on the first disabled clk
        tag = "dis_pend";
        run_until(2);
        set_in(0, 9, 16'd4, 16'd0, 16'd0, 16'd0, 4'b0101);
        ld_cyc();
        en = 1'b0;
        cyc();
        repeat (3) cyc();

        // load while disabled, then re-enable from a full period
        tag = "dis_load";
        set_in(0, 9, 16'd2, 16'd0, 16'd0, 16'd0, 4'b0000);
        ld_cyc();
        cyc();
        tag = "reen";
        en = 1'b1;
        repeat (12) cyc();

        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain queue left=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; next generation of the team's single-channel PWM.
- All channels share one prescaler and one period counter. Each channel has its own duty and output polarity.
- Configuration is double-buffered: new period and duty values take effect only at a period boundary, so no glitched cycle is ever produced.
- Sits between the control registers / motion controller and the motor or servo drivers.

Parameters:
CHANNELS, 4, number of independent PWM outputs
CNT_W, 16, width of the period counter and each duty value
PRESC_W, 8, width of the prescaler divide value

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous active-low
en  input  1  run enable; low = counters held, outputs idle
presc  input  PRESC_W  one counter tick every presc+1 clk cycles
period  input  CNT_W  PWM period = period+1 ticks
duty  input  CHANNELS*CNT_W  per-channel high-time in ticks; channel i uses bits [i*CNT_W +: CNT_W]
pol  input  CHANNELS  per-channel polarity; 1 inverts the output
load  input  1  one-cycle strobe; captures presc/period/duty/pol into the pending registers
pwm_out  output  CHANNELS  registered PWM outputs
period_tick  output  1  one-cycle pulse on each period wrap
pending  output  1  high while a loaded configuration is waiting to be applied

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All counters = 0.
  - Active and pending registers = 0.
  - pending = 0, period_tick = 0, pwm_out = 0.
  - Reset asserted mid-period clears everything immediately; no completion of the running period.
- Register sets: an active set (presc_a, period_a, duty_a[i], pol_a[i]) and a pending set of the same fields.
- load=1: the pending set captures the inputs and the pending flag sets.
  - A second load before the set is applied overwrites the pending set; the last load wins.
- Prescaler:
  - When en=1, pcnt counts 0..presc_a.
  - tick = (pcnt==presc_a). pcnt wraps to 0 on tick.
  - presc_a=0 gives tick every clk.
- Period counter:
  - On tick, cnt increments. If cnt==period_a, cnt wraps to 0 instead.
  - wrap = tick && cnt==period_a.
  - period_a=0 gives a wrap on every tick.
- Boundary update:
  - On wrap, if the pending flag is set: copy pending to active, clear the flag, reset pcnt and cnt to 0.
  - If load and wrap occur in the same cycle, the freshly loaded input values are applied directly at that wrap and the flag stays 0.
- period_tick: registered; high for exactly one clk, the cycle after each wrap.
- Compare, per channel: raw_i = (cnt < duty_a[i]).
  - duty_a[i]=0: always low.
  - duty_a[i] > period_a: always high (100%); no wrap-around artefacts.
  - Comparison is unsigned CNT_W-bit.
- Output: pwm_out[i] is registered from raw_i XOR pol_a[i]. Latency is 1 clk from a counter change to the output change.
- Disabled (en=0):
  - pcnt and cnt are held at 0.
  - pwm_out[i] = pol_a[i], i.e. inactive level.
  - No period_tick.
  - A pending set (or a load) is applied to the active set on the next clk, without waiting for a wrap.
- Re-enable: counting restarts at cnt=0 with a full period. The first output is active if duty_a>0.

Test Plan:
- Reset then load presc=0, period=9, duty[0]=3, pol=0, en=1 → pwm_out[0] high 3 clk, low 7 clk, repeating; period_tick every 10 clk.
- presc=3, period=4, duty[1]=2 → pwm_out[1] high 8 clk, low 12 clk; pcnt wraps every 4 clk.
- Edge duties, period=9: duty 0 → constant 0; duty 10 or 0xFFFF → constant 1; pol=1 with duty 3 → low 3, high 7.
- Mid-period load of duty 7 when cnt=4 (old duty 3) → no change until wrap, pending=1; from next period 7 high / 3 low; pending clears on the wrap.
- load coincident with wrap → new values are used in the very next period and pending never rises; two loads before a wrap → only the second is applied.
- Assert rst_n=0 mid-high-phase (asynchronously, between edges) → pwm_out and period_tick drop immediately; en=0 → outputs held at pol and load is applied within 1 clk.
